hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage MIPS pipeline.
- Compares D-stage source registers against E/M destinations using Tuse/Tnew, and tracks the multi-cycle mult/div unit with an internal busy counter.
- Holds ERET in D until EPC writes drain, and applies exception flush (req).
- Drives the write-enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.
- CNT_W, 4, width of the busy counter; must hold DIV_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  exception/interrupt request from CP0, same cycle as the M-stage flush.
- D_rs  input  5  D-stage rs address.
- D_rt  input  5  D-stage rt address.
- D_Tuse_rs  input  2  cycles until D needs rs (3 = unused).
- D_Tuse_rt  input  2  cycles until D needs rt (3 = unused).
- D_is_md  input  1  D instruction reads/writes HI/LO or starts mult/div.
- D_eret  input  1  D instruction is ERET.
- E_A3  input  5  E-stage destination register.
- E_Tnew  input  2  cycles until the E result is available.
- M_A3  input  5  M-stage destination register.
- M_Tnew  input  2  cycles until the M result is available.
- E_md_start  input  1  E instruction is mult/multu/div/divu.
- E_md_is_div  input  1  qualifies E_md_start as a divide.
- E_mtc0_epc  input  1  E instruction is MTC0 to EPC.
- M_mtc0_epc  input  1  M instruction is MTC0 to EPC.
- PC_WE  output  1  PC write enable.
- FD_WE  output  1  F/D register write enable.
- DE_clr  output  1  D/E register clear (bubble insert).
- EM_WE  output  1  E/M write enable; always 1.
- MW_WE  output  1  M/W write enable; always 1.
- md_busy  output  1  mult/div unit busy.
- stall  output  1  stall decision, exposed for debug.

Behaviour:
- Reset: busy counter = 0. With no other activity this gives md_busy=0, stall=0, PC_WE=1, FD_WE=1, DE_clr=0, EM_WE=MW_WE=1.
- Busy counter (cnt), the only sequential state:
  - reset → cnt = 0.
  - Else if req → cnt unchanged, and a coincident E_md_start is ignored (the faulting E instruction never issues).
  - Else if E_md_start → cnt = E_md_is_div ? DIV_CYCLES : MULT_CYCLES. This overrides any decrement.
  - Else if cnt ≠ 0 → cnt decrements by 1.
  - md_busy = (cnt ≠ 0), registered-state derived.
  - A mult issued at edge k gives md_busy=1 for exactly MULT_CYCLES cycles, low on cycle k+MULT_CYCLES.
- Register hazard, combinational:
  - stall_rs = D_rs≠0 and ((D_rs==E_A3 and D_Tuse_rs<E_Tnew) or (D_rs==M_A3 and D_Tuse_rs<M_Tnew)).
  - stall_rt is identical with D_rt.
  - Register $0 never stalls. E_A3==M_A3 matches are checked independently, so either can stall.
- MD hazard: stall_md = D_is_md and (md_busy or E_md_start). This covers the cycle a start sits in E before cnt loads.
- ERET hazard: stall_eret = D_eret and (E_mtc0_epc or M_mtc0_epc).
- stall = (stall_rs | stall_rt | stall_md | stall_eret) & ~req.
- Output mapping:
  - PC_WE = FD_WE = ~stall.
  - DE_clr = stall.
  - req forces PC_WE=1, FD_WE=1, DE_clr=0. The stage registers perform the req flush themselves; the PC loads the handler vector 0x4180.
- A stall never blocks E/M or M/W, so producers always drain and every stall terminates within at most max(3, DIV_CYCLES+1) cycles.
- reset asserted mid-divide → cnt=0 next edge; md_busy drops immediately after that edge.
- All outputs except the cnt update are combinational from current inputs and cnt. No output register adds latency.

Decomposition:
- Shared package constants: TUSE_NONE=2'd3, MULT_CYCLES/DIV_CYCLES defaults, EXC_HANDLER_PC=32'h0000_4180.
- One natural sub-module: md_busy_counter, holding cnt, the load/decrement logic and md_busy.
- Hazard comparison stays flat in hazard_ctrl.

Test Plan:
- Load-use: D_rs=5, D_Tuse_rs=0, E_A3=5, E_Tnew=2 → stall=1, PC_WE=0, FD_WE=0, DE_clr=1. Then E_A3=0 with M_A3=5, M_Tnew=1 → stall=1. Then M_Tnew=0 → stall=0.
- $0 and ordering: D_rs=0, E_A3=0, E_Tnew=2 → stall=0. D_rt=7, D_Tuse_rt=1, E_A3=7, E_Tnew=1 → stall=0.
- Mult timing: E_md_start=1, is_div=0 at edge 0 → md_busy high on cycles 1..5, low on cycle 6. D_is_md=1 throughout → stall=1 through cycle 5 and also in cycle 0 (start in E).
- Div + reset: issue div, assert reset at cycle 4 → md_busy=0 the cycle after reset. Issue div then mult at cnt=3 → cnt reloads 5.
- Exception: req=1 with stall_rs true and E_md_start=1 → stall=0, PC_WE=1, DE_clr=0, cnt not loaded (md_busy stays 0).
- ERET: D_eret=1, E_mtc0_epc=1 → stall=1 for 2 cycles as the mtc0 moves E→M→W. Then stall=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared constants, types and helpers for the pipeline hazard controller.
//   TUSE_NONE       : Tuse encoding meaning "this source operand is not read".
//   *_DEF           : default latencies of the multi-cycle mult/div unit.
//   EXC_HANDLER_PC  : vector the PC loads when an exception request is taken.
//   stall_cause_t   : one bit per stall reason, used internally and for debug.
//   reg_hazard()    : Tuse/Tnew comparison for one source vs. one producer.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;
    localparam int          CNT_W_DEF       = 4;
    localparam logic [31:0] EXC_HANDLER_PC  = 32'h0000_4180;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

    typedef struct packed {
        logic rs;
        logic rt;
        logic md;
        logic eret;
    } stall_cause_t;

    // A source must wait when its producer still needs more cycles (tnew) than
    // the consumer can afford to wait before using the value (tuse). $0 is
    // hard-wired, so it never creates a dependency. TUSE_NONE (3) can never be
    // below a 2-bit tnew, so unused operands drop out without a special case.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src != REG_ZERO) && (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Tracks how many cycles the multi-cycle mult/div unit remains busy.
// Ports:
//   clk      in  : system clock, rising edge
//   reset    in  : synchronous active-high reset, clears the counter
//   req      in  : exception request; the faulting E instruction never issues,
//                  so a coincident start is ignored and the count is held
//   start    in  : E instruction is mult/multu/div/divu
//   is_div   in  : selects the divide latency for start
//   md_busy  out : counter non-zero (derived from registered state only)
// -----------------------------------------------------------------------------
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Priority: exception hold > new issue (overrides any decrement) > drain.
    always_comb begin
        cnt_next = cnt_reg;
        if (req) begin
            cnt_next = cnt_reg;
        end else if (start) begin
            cnt_next = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_reg != CNT_ZERO) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= CNT_ZERO;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign md_busy = (cnt_reg != CNT_ZERO);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush controller for the five-stage MIPS pipeline.
// Compares D-stage sources against E/M destinations with Tuse/Tnew, holds
// HI/LO users while the mult/div unit is busy, holds ERET until EPC writes
// have drained, and lets an exception request override every stall.
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   req                     : exception/interrupt request (M-stage flush)
//   D_rs/D_rt, D_Tuse_*     : D-stage sources and their Tuse (3 = unused)
//   D_is_md, D_eret         : D instruction touches HI/LO or mult/div; is ERET
//   E_A3/E_Tnew, M_A3/M_Tnew: producer destinations and their Tnew
//   E_md_start, E_md_is_div : E instruction starts mult/div (div qualifier)
//   E_mtc0_epc, M_mtc0_epc  : MTC0 to EPC currently in E / M
//   PC_WE, FD_WE            : PC and F/D write enables (low while stalling)
//   DE_clr                  : D/E clear, inserts the bubble while stalling
//   EM_WE, MW_WE            : always 1; later stages drain during a stall
//   md_busy, stall          : mult/div busy flag and raw stall decision
// All outputs are combinational from current inputs and the busy counter.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic       D_is_md,
    input  logic       D_eret,
    input  logic [4:0] E_A3,
    input  logic [1:0] E_Tnew,
    input  logic [4:0] M_A3,
    input  logic [1:0] M_Tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    output logic       PC_WE,
    output logic       FD_WE,
    output logic       DE_clr,
    output logic       EM_WE,
    output logic       MW_WE,
    output logic       md_busy,
    output logic       stall
);

    localparam int NUM_SRC = 2;

    logic [NUM_SRC-1:0][4:0] src_addr;
    logic [NUM_SRC-1:0][1:0] src_tuse;
    logic [NUM_SRC-1:0]      src_stall;
    stall_cause_t            cause;
    logic                    stall_any;

    // ---------------------------------------------------------------------
    // Mult/div busy tracking
    // ---------------------------------------------------------------------
    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .start   (E_md_start),
        .is_div  (E_md_is_div),
        .md_busy (md_busy)
    );

    // ---------------------------------------------------------------------
    // Register hazards: rs and rt are checked by identical logic. E and M are
    // compared independently, so when both write the same register either
    // one can cause the stall (E holds the newer value, M may still be late).
    // ---------------------------------------------------------------------
    assign src_addr[0] = D_rs;
    assign src_addr[1] = D_rt;
    assign src_tuse[0] = D_Tuse_rs;
    assign src_tuse[1] = D_Tuse_rt;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_stall[gi] =
                reg_hazard(src_addr[gi], src_tuse[gi], E_A3, E_Tnew) |
                reg_hazard(src_addr[gi], src_tuse[gi], M_A3, M_Tnew);
        end
    endgenerate

    assign cause.rs   = src_stall[0];
    assign cause.rt   = src_stall[1];

    // A start sitting in E has not loaded the counter yet, so it must also
    // hold a HI/LO user in D for that one cycle.
    assign cause.md   = D_is_md & (md_busy | E_md_start);

    // ERET reads EPC in D; wait until any in-flight MTC0 EPC has written back.
    assign cause.eret = D_eret & (E_mtc0_epc | M_mtc0_epc);

    assign stall_any  = |cause;

    // The exception flush wins: the PC must load the handler vector and the
    // stage registers flush themselves, so no stall may freeze them.
    assign stall  = stall_any & ~req;

    assign PC_WE  = req | ~stall;
    assign FD_WE  = req | ~stall;
    assign DE_clr = stall & ~req;

    // Later stages never stall, which guarantees every hazard drains.
    assign EM_WE  = 1'b1;
    assign MW_WE  = 1'b1;

endmodule
